// File: rtl/up_down_counter_param.sv
// rtl/up_down_counter_param.sv - synchronous up/down counter with modulus, load, clear and wrap/saturate mode
module up_down_counter_param #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic at_top;
  logic at_bottom;

  assign at_top    = (count == MAX_V);
  assign at_bottom = (count == '0);

  // Cascade signal: a following stage should use en_next = en & tc.
  assign tc = up_down ? at_top : at_bottom;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      wrap     <= 1'b0;
      at_limit <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      wrap     <= 1'b0;
      at_limit <= 1'b0;
    end else if (load) begin
      count    <= (load_val > MAX_V) ? MAX_V : load_val;
      wrap     <= 1'b0;
      at_limit <= 1'b0;
    end else if (en) begin
      wrap     <= 1'b0;
      at_limit <= 1'b0;
      if (up_down) begin
        if (!at_top) begin
          count <= count + ONE;
        end else if (SATURATE) begin
          at_limit <= 1'b1;
        end else begin
          count <= '0;
          wrap  <= 1'b1;
        end
      end else begin
        if (!at_bottom) begin
          count <= count - ONE;
        end else if (SATURATE) begin
          at_limit <= 1'b1;
        end else begin
          count <= MAX_V;
          wrap  <= 1'b1;
        end
      end
    end else begin
      wrap     <= 1'b0;
      at_limit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_up_down_counter_param.sv
// tb/tb_up_down_counter_param.sv - directed vector bench for up_down_counter_param
module tb_up_down_counter_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_down = 1'b0;
  logic       load = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       en_c = 1'b0;

  logic [3:0] a_count, b_count, c_count, lo_count, hi_count;
  logic       a_tc, b_tc, c_tc, lo_tc, hi_tc;
  logic       a_wrap, b_wrap, c_wrap, lo_wrap, hi_wrap;
  logic       a_lim, b_lim, c_lim, lo_lim, hi_lim;
  logic       hi_en;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .clear(clear), .count(a_count), .tc(a_tc), .wrap(a_wrap), .at_limit(a_lim));

  up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u_b (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .clear(clear), .count(b_count), .tc(b_tc), .wrap(b_wrap), .at_limit(b_lim));

  up_down_counter_param #(.WIDTH(4), .MAX_VAL(1), .SATURATE(1'b0)) u_c (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
    .clear(clear), .count(c_count), .tc(c_tc), .wrap(c_wrap), .at_limit(c_lim));

  up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_lo (
    .clk(clk), .rst(rst), .en(en_c), .up_down(1'b1), .load(1'b0), .load_val(4'd0),
    .clear(1'b0), .count(lo_count), .tc(lo_tc), .wrap(lo_wrap), .at_limit(lo_lim));

  assign hi_en = en_c & lo_tc;

  up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_hi (
    .clk(clk), .rst(rst), .en(hi_en), .up_down(1'b1), .load(1'b0), .load_val(4'd0),
    .clear(1'b0), .count(hi_count), .tc(hi_tc), .wrap(hi_wrap), .at_limit(hi_lim));

  typedef struct {
    logic       clr;
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       ud;
    logic [3:0] a_cnt;
    logic       a_wrap;
    logic       a_tc;
    logic [3:0] b_cnt;
    logic       b_lim;
    logic       b_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int clr, input int ld, input int lv, input int e, input int ud,
                     input int ac, input int aw, input int at,
                     input int bc, input int bl, input int bt);
    vec_t v;
    v.clr = clr[0]; v.ld = ld[0]; v.lv = lv[3:0]; v.en = e[0]; v.ud = ud[0];
    v.a_cnt = ac[3:0]; v.a_wrap = aw[0]; v.a_tc = at[0];
    v.b_cnt = bc[3:0]; v.b_lim = bl[0]; v.b_tc = bt[0];
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int clr, input int ld, input int lv, input int e, input int ud);
    clear = clr[0]; load = ld[0]; load_val = lv[3:0]; en = e[0]; up_down = ud[0];
    @(negedge clk);
  endtask

  int lo_wraps;
  int hi_wraps;

  initial begin
    // count up through the wrap
    for (int k = 1; k <= 8; k++) add(0, 0, 0, 1, 1, k, 0, 0, k, 0, 0);
    add(0, 0, 0, 1, 1, 9, 0, 1, 9, 0, 1);
    add(0, 0, 0, 1, 1, 0, 1, 0, 9, 1, 1);
    add(0, 0, 0, 1, 1, 1, 0, 0, 9, 1, 1);
    add(0, 0, 0, 1, 1, 2, 0, 0, 9, 1, 1);
    // load 3, count down through zero
    add(0, 1, 3, 0, 0, 3, 0, 0, 3, 0, 0);
    add(0, 0, 0, 1, 0, 2, 0, 0, 2, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0, 9, 1, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 8, 0, 0, 0, 1, 1);
    // load 8 with en high, saturate at top, then reverse
    add(0, 1, 8, 1, 1, 8, 0, 0, 8, 0, 0);
    add(0, 0, 0, 1, 1, 9, 0, 1, 9, 0, 1);
    add(0, 0, 0, 1, 1, 0, 1, 0, 9, 1, 1);
    add(0, 0, 0, 1, 1, 1, 0, 0, 9, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1, 8, 0, 0);
    // priority, clamp, load over en, hold
    add(1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 15, 0, 1, 9, 0, 1, 9, 0, 1);
    add(0, 1, 5, 1, 1, 5, 0, 0, 5, 0, 0);
    add(0, 0, 0, 0, 0, 5, 0, 0, 5, 0, 0);

    @(negedge clk);
    chk("reset_a_count", a_count, 0);
    chk("reset_a_wrap", a_wrap, 0);
    chk("reset_b_at_limit", b_lim, 0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ud);
      chk($sformatf("v%0d_a_count", i), a_count, vecs[i].a_cnt);
      chk($sformatf("v%0d_a_wrap", i), a_wrap, vecs[i].a_wrap);
      chk($sformatf("v%0d_a_tc", i), a_tc, vecs[i].a_tc);
      chk($sformatf("v%0d_a_at_limit", i), a_lim, 0);
      chk($sformatf("v%0d_b_count", i), b_count, vecs[i].b_cnt);
      chk($sformatf("v%0d_b_at_limit", i), b_lim, vecs[i].b_lim);
      chk($sformatf("v%0d_b_tc", i), b_tc, vecs[i].b_tc);
      chk($sformatf("v%0d_b_wrap", i), b_wrap, 0);
    end

    // MAX_VAL=1: back-to-back wraps keep wrap high
    step(1, 0, 0, 0, 0); chk("c_clear", c_count, 0);
    step(0, 0, 0, 1, 1); chk("c_up1", c_count, 1); chk("c_up1_wrap", c_wrap, 0);
    step(0, 0, 0, 1, 1); chk("c_up0", c_count, 0); chk("c_up0_wrap", c_wrap, 1);
    step(0, 0, 0, 1, 0); chk("c_dn1", c_count, 1); chk("c_dn1_wrap", c_wrap, 1);
    step(0, 0, 0, 1, 1); chk("c_up0b", c_count, 0); chk("c_up0b_wrap", c_wrap, 1);
    step(0, 1, 7, 0, 0); chk("c_clamp", c_count, 1); chk("c_clamp_wrap", c_wrap, 0);
    chk("a_load7", a_count, 7);
    step(0, 0, 0, 1, 1); chk("a_8", a_count, 8); chk("c_wrap_up", c_wrap, 1);
    step(0, 0, 0, 1, 0); chk("a_7", a_count, 7); chk("c_wrap_pending", c_wrap, 1);

    // asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    chk("async_a_count", a_count, 0);
    chk("async_c_count", c_count, 0);
    chk("async_c_wrap", c_wrap, 0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_hold", a_count, 0);
    step(0, 0, 0, 1, 1);
    chk("post_reset_first", a_count, 1);

    // two-stage decade cascade
    en = 1'b0;
    en_c = 1'b1;
    lo_wraps = 0;
    hi_wraps = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (lo_wrap) lo_wraps++;
      if (hi_wrap) hi_wraps++;
      if (i == 37) begin
        chk("casc37_hi", hi_count, 3);
        chk("casc37_lo", lo_count, 7);
      end
      if (i == 99) chk("casc99_hi_tc", hi_tc, 1);
    end
    en_c = 1'b0;
    chk("casc100_hi", hi_count, 0);
    chk("casc100_lo", lo_count, 0);
    chk("casc100_hi_wrap_now", hi_wrap, 1);
    chk("casc_hi_wraps", hi_wraps, 1);
    chk("casc_lo_wraps", lo_wraps, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
